// File: rtl/mau_pkg.sv
// rtl/mau_pkg.sv - shared encodings and constants for the memory access unit
package mau_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_WRITE,
        ST_RESP
    } state_e;

    // Size 11 is never legal; half and word must sit on their natural boundary.
    function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        if (size == SIZE_ILL) begin
            bad = 1'b1;
        end else if (size == SIZE_HALF) begin
            bad = offset[0];
        end else if (size == SIZE_WORD) begin
            bad = (offset != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/mau_lane.sv
// rtl/mau_lane.sv - byte-lane merge for sub-word stores and lane extract/extend for loads
module mau_lane
    import mau_pkg::*;
(
    input  logic [1:0]        offset,
    input  logic [1:0]        size,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] merged,
    output logic [DATA_W-1:0] extended
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{offset, 3'b000} +: 8];
        half_lane = rdata[{offset[1], 4'b0000} +: 16];

        merged = rdata;
        case (size)
            SIZE_BYTE: merged[{offset, 3'b000} +: 8]    = wdata[7:0];
            SIZE_HALF: merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            SIZE_WORD: merged = wdata;
            default:   merged = rdata;
        endcase

        extended = '0;
        case (size)
            SIZE_BYTE: extended = {{24{is_signed & byte_lane[7]}}, byte_lane};
            SIZE_HALF: extended = {{16{is_signed & half_lane[15]}}, half_lane};
            SIZE_WORD: extended = rdata;
            default:   extended = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store front end between execute stage and word-wide datamem
module mem_access_unit
    import mau_pkg::*;
#(
    parameter  int DM_AW  = 12,
    localparam int ADDR_W = DM_AW + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              we_DM,
    output logic [DM_AW-1:0]  addDM,
    output logic [DATA_W-1:0] dataDM,
    input  logic [DATA_W-1:0] outDM
);

    state_e              state_q, state_d;
    logic                lat_we_q, lat_we_d;
    logic [1:0]          lat_size_q, lat_size_d;
    logic                lat_signed_q, lat_signed_d;
    logic [1:0]          lat_off_q, lat_off_d;
    logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;
    logic [DM_AW-1:0]    add_dm_q, add_dm_d;
    logic [DATA_W-1:0]   data_dm_q, data_dm_d;

    logic                accept;
    logic                bad_req;
    logic [DATA_W-1:0]   lane_merged;
    logic [DATA_W-1:0]   lane_extended;

    mau_lane u_lane (
        .offset    (lat_off_q),
        .size      (lat_size_q),
        .is_signed (lat_signed_q),
        .wdata     (lat_wdata_q),
        .rdata     (outDM),
        .merged    (lane_merged),
        .extended  (lane_extended)
    );

    always_comb begin
        state_d      = state_q;
        lat_we_d     = lat_we_q;
        lat_size_d   = lat_size_q;
        lat_signed_d = lat_signed_q;
        lat_off_d    = lat_off_q;
        lat_wdata_d  = lat_wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        add_dm_d     = add_dm_q;
        data_dm_d    = data_dm_q;

        req_ready = (state_q == ST_IDLE);
        accept    = req_valid && req_ready;
        bad_req   = req_is_bad(req_size, req_addr[1:0]);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    lat_we_d     = req_we;
                    lat_size_d   = req_size;
                    lat_signed_d = req_signed;
                    lat_off_d    = req_addr[1:0];
                    lat_wdata_d  = req_wdata;
                    resp_rdata_d = '0;
                    resp_err_d   = bad_req;
                    if (bad_req) begin
                        state_d = ST_RESP;
                    end else begin
                        add_dm_d = req_addr[ADDR_W-1:2];
                        // Full-word stores need no read of the old contents.
                        if (req_we && (req_size == SIZE_WORD)) begin
                            data_dm_d = req_wdata;
                            state_d   = ST_WRITE;
                        end else begin
                            state_d = ST_RD_WAIT;
                        end
                    end
                end
            end
            ST_RD_WAIT: begin
                if (lat_we_q) begin
                    data_dm_d = lane_merged;
                    state_d   = ST_WRITE;
                end else begin
                    resp_rdata_d = lane_extended;
                    state_d      = ST_RESP;
                end
            end
            ST_WRITE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        resp_valid = (state_q == ST_RESP);
        we_DM      = (state_q == ST_WRITE) && !rst;
        addDM      = add_dm_q;
        dataDM     = data_dm_q;
        resp_rdata = resp_rdata_q;
        resp_err   = resp_err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            lat_we_q     <= 1'b0;
            lat_size_q   <= 2'b00;
            lat_signed_q <= 1'b0;
            lat_off_q    <= 2'b00;
            lat_wdata_q  <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            add_dm_q     <= '0;
            data_dm_q    <= '0;
        end else begin
            state_q      <= state_d;
            lat_we_q     <= lat_we_d;
            lat_size_q   <= lat_size_d;
            lat_signed_q <= lat_signed_d;
            lat_off_q    <= lat_off_d;
            lat_wdata_q  <= lat_wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            add_dm_q     <= add_dm_d;
            data_dm_q    <= data_dm_d;
        end
    end

endmodule
